// File: rtl/instruction_decode_status.sv
// ---------------------------------------------------------------------------
// instruction_decode_status
//
// Purpose:
//   Holds the instruction register (IR) and the processor status register
//   (PSR) of the 16-bit core. Splits the IR into the opcode and register
//   fields used by the controller and datapath, builds the three immediate
//   variants, and evaluates the Bcond/Jcond condition code in IR[11:8]
//   against the registered PSR. The result gates the branch displacement:
//   a not-taken branch yields a displacement of 1, which steps PC past the
//   branch.
//
// Ports:
//   clock                        system clock, rising-edge active
//   reset                        asynchronous, active-high; clears all state
//   instruction_write_enable     load IR from instruction_read_data
//   instruction_read_data [15:0] memory read data for the IR load
//   status_write_enable          load PSR from alu_flags
//   alu_flags [4:0]              {C,L,F,Z,N} from the ALU
//   instruction_operation [3:0]  IR[15:12]
//   instruction_operation_extra  IR[7:4]
//   register_destination [3:0]   IR[11:8]
//   register_source [3:0]        IR[3:0]
//   immediate_sign_extended      sign-extended IR[7:0]
//   immediate_zero_extended      zero-extended IR[7:0]
//   immediate_upper              {IR[7:0], 8'h00}
//   immediate_sign_extended_cond sign-extended IR[7:0] if condition passes,
//                                otherwise 1
//   condition_pass               condition code IR[11:8] against the PSR
//   status [4:0]                 current PSR {C,L,F,Z,N}
//   instruction_valid            IR has been loaded at least once
//
// Optional feature (macro ILLEGAL_DETECT_EN):
//   illegal_instruction          sticky flag, set by the load of an
//                                illegal instruction
//   illegal_count [7:0]          number of illegal loads, saturating at FF
// ---------------------------------------------------------------------------
module instruction_decode_status #(
  parameter int                 WIDTH             = 16,
  parameter logic [WIDTH-1:0]   RESET_INSTRUCTION = 16'h0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instruction_write_enable,
  input  logic [WIDTH-1:0] instruction_read_data,
  input  logic             status_write_enable,
  input  logic [4:0]       alu_flags,
  output logic [3:0]       instruction_operation,
  output logic [3:0]       instruction_operation_extra,
  output logic [3:0]       register_destination,
  output logic [3:0]       register_source,
  output logic [WIDTH-1:0] immediate_sign_extended,
  output logic [WIDTH-1:0] immediate_zero_extended,
  output logic [WIDTH-1:0] immediate_upper,
  output logic [WIDTH-1:0] immediate_sign_extended_cond,
  output logic             condition_pass,
  output logic [4:0]       status,
  output logic             instruction_valid
`ifdef ILLEGAL_DETECT_EN
  ,
  output logic             illegal_instruction,
  output logic [7:0]       illegal_count
`endif
);

  logic [WIDTH-1:0] ir_q, ir_d;
  logic [4:0]       psr_q, psr_d;
  logic             valid_q, valid_d;

  // PSR bit positions follow the ALU flag bundle {C,L,F,Z,N}.
  logic flag_c, flag_l, flag_f, flag_z, flag_n;
  assign flag_c = psr_q[4];
  assign flag_l = psr_q[3];
  assign flag_f = psr_q[2];
  assign flag_z = psr_q[1];
  assign flag_n = psr_q[0];

  // Next-state for IR, PSR and the valid flag. Both registers may load on
  // the same edge; they are independent.
  always_comb begin
    ir_d    = ir_q;
    psr_d   = psr_q;
    valid_d = valid_q;
    if (instruction_write_enable) begin
      ir_d    = instruction_read_data;
      valid_d = 1'b1;
    end
    if (status_write_enable) begin
      psr_d = alu_flags;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_q    <= RESET_INSTRUCTION;
      psr_q   <= 5'b0;
      valid_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      psr_q   <= psr_d;
      valid_q <= valid_d;
    end
  end

  // Field extraction.
  assign instruction_operation       = ir_q[15:12];
  assign register_destination        = ir_q[11:8];
  assign instruction_operation_extra = ir_q[7:4];
  assign register_source             = ir_q[3:0];

  assign immediate_sign_extended = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
  assign immediate_zero_extended = {{(WIDTH-8){1'b0}}, ir_q[7:0]};
  assign immediate_upper         = {ir_q[7:0], {(WIDTH-8){1'b0}}};

  // Condition evaluation uses only the registered PSR, so a flag update is
  // visible to a branch one cycle after the status write.
  always_comb begin
    condition_pass = 1'b0;
    case (ir_q[11:8])
      4'b0000: condition_pass = flag_z;
      4'b0001: condition_pass = ~flag_z;
      4'b0010: condition_pass = flag_c;
      4'b0011: condition_pass = ~flag_c;
      4'b0100: condition_pass = flag_l;
      4'b0101: condition_pass = ~flag_l;
      4'b0110: condition_pass = flag_n;
      4'b0111: condition_pass = ~flag_n;
      4'b1000: condition_pass = flag_f;
      4'b1001: condition_pass = ~flag_f;
      4'b1010: condition_pass = ~flag_l & ~flag_z;
      4'b1011: condition_pass = flag_l | flag_z;
      4'b1100: condition_pass = ~flag_n & ~flag_z;
      4'b1101: condition_pass = flag_n | flag_z;
      4'b1110: condition_pass = 1'b1;
      4'b1111: condition_pass = 1'b0;
      default: condition_pass = 1'b0;
    endcase
  end

  // A failed condition yields displacement 1 so PC simply moves on.
  assign immediate_sign_extended_cond = condition_pass ? immediate_sign_extended
                                                       : {{(WIDTH-1){1'b0}}, 1'b1};

  assign status            = psr_q;
  assign instruction_valid = valid_q;

`ifdef ILLEGAL_DETECT_EN
  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_MEMORY = 4'b0100;
  localparam logic [3:0] OP_LSH    = 4'b1000;

  logic       illegal_q, illegal_d;
  logic [7:0] count_q, count_d;
  logic       load_is_illegal;

  // Classify the word being loaded so the flag and count update on the
  // very edge that loads the offending instruction.
  always_comb begin
    load_is_illegal = 1'b0;
    case (instruction_read_data[15:12])
      4'b0110, 4'b0111, 4'b1010, 4'b1110: load_is_illegal = 1'b1;
      OP_RTYPE: begin
        case (instruction_read_data[7:4])
          4'b0101, 4'b1001, 4'b1011, 4'b0001,
          4'b0010, 4'b0011, 4'b1101: load_is_illegal = 1'b0;
          default:                   load_is_illegal = 1'b1;
        endcase
      end
      OP_LSH: begin
        case (instruction_read_data[7:4])
          4'b0100, 4'b0000, 4'b0001: load_is_illegal = 1'b0;
          default:                   load_is_illegal = 1'b1;
        endcase
      end
      OP_MEMORY: begin
        case (instruction_read_data[7:4])
          4'b0000, 4'b0100, 4'b1100, 4'b1000: load_is_illegal = 1'b0;
          default:                            load_is_illegal = 1'b1;
        endcase
      end
      default: load_is_illegal = 1'b0;
    endcase
  end

  // Sticky flag plus saturating counter of illegal loads.
  always_comb begin
    illegal_d = illegal_q;
    count_d   = count_q;
    if (instruction_write_enable && load_is_illegal) begin
      illegal_d = 1'b1;
      if (count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign illegal_instruction = illegal_q;
  assign illegal_count       = count_q;
`endif

endmodule

// File: tb/tb_instruction_decode_status.sv
// ---------------------------------------------------------------------------
// tb_instruction_decode_status
//
// Scoreboard bench: the stimulus process pushes the expected output set into
// a queue after each action, and a monitor process pops and compares the
// DUT outputs on the following falling edge (or immediately when asked,
// for the asynchronous reset check).
// ---------------------------------------------------------------------------
module tb_instruction_decode_status;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instruction_write_enable = 1'b0;
  logic [15:0] instruction_read_data = 16'h0000;
  logic        status_write_enable = 1'b0;
  logic [4:0]  alu_flags = 5'b0;

  logic [3:0]  instruction_operation;
  logic [3:0]  instruction_operation_extra;
  logic [3:0]  register_destination;
  logic [3:0]  register_source;
  logic [15:0] immediate_sign_extended;
  logic [15:0] immediate_zero_extended;
  logic [15:0] immediate_upper;
  logic [15:0] immediate_sign_extended_cond;
  logic        condition_pass;
  logic [4:0]  status;
  logic        instruction_valid;
`ifdef ILLEGAL_DETECT_EN
  logic        illegal_instruction;
  logic [7:0]  illegal_count;
`endif

  instruction_decode_status dut (
    .clock                        (clock),
    .reset                        (reset),
    .instruction_write_enable     (instruction_write_enable),
    .instruction_read_data        (instruction_read_data),
    .status_write_enable          (status_write_enable),
    .alu_flags                    (alu_flags),
    .instruction_operation        (instruction_operation),
    .instruction_operation_extra  (instruction_operation_extra),
    .register_destination         (register_destination),
    .register_source              (register_source),
    .immediate_sign_extended      (immediate_sign_extended),
    .immediate_zero_extended      (immediate_zero_extended),
    .immediate_upper              (immediate_upper),
    .immediate_sign_extended_cond (immediate_sign_extended_cond),
    .condition_pass               (condition_pass),
    .status                       (status),
    .instruction_valid            (instruction_valid)
`ifdef ILLEGAL_DETECT_EN
    ,
    .illegal_instruction          (illegal_instruction),
    .illegal_count                (illegal_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int          tag;
    bit          full;
    logic [3:0]  op;
    logic [3:0]  ex;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] se;
    logic [15:0] ze;
    logic [15:0] up;
    logic [15:0] cond;
    logic        pass;
    logic [4:0]  st;
    logic        valid;
    logic        ill;
    logic [7:0]  cnt;
  } expect_t;

  expect_t exp_q[$];
  event    sample_now;
  int      tests_run = 0;
  int      tests_failed = 0;
  int      pushed = 0;
  int      popped = 0;
  int      next_tag = 0;

  // Compare one field of one record.
  task automatic checkOutput(input string name, input int tag,
                             input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s (record %0d): got %h, expected %h", name, tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge; enables drop just after
  // the rising edge that consumes them.
  task automatic applyStimulus(input logic iwe, input logic [15:0] data,
                               input logic swe, input logic [4:0] flags);
    @(negedge clock);
    instruction_write_enable = iwe;
    instruction_read_data    = data;
    status_write_enable      = swe;
    alu_flags                = flags;
    @(posedge clock);
    #1;
    instruction_write_enable = 1'b0;
    status_write_enable      = 1'b0;
  endtask

  task automatic pushFull(input logic [3:0] op, input logic [3:0] rd,
                          input logic [3:0] ex, input logic [3:0] rs,
                          input logic [15:0] se, input logic [15:0] ze,
                          input logic [15:0] up, input logic [15:0] cond,
                          input logic pass, input logic [4:0] st,
                          input logic valid, input logic ill, input logic [7:0] cnt);
    expect_t e;
    e.tag = next_tag++; e.full = 1'b1;
    e.op = op; e.rd = rd; e.ex = ex; e.rs = rs;
    e.se = se; e.ze = ze; e.up = up; e.cond = cond;
    e.pass = pass; e.st = st; e.valid = valid; e.ill = ill; e.cnt = cnt;
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic pushCond(input logic pass, input logic [15:0] cond, input logic [4:0] st);
    expect_t e;
    e.tag = next_tag++; e.full = 1'b0;
    e.op = 4'h0; e.rd = 4'h0; e.ex = 4'h0; e.rs = 4'h0;
    e.se = 16'h0; e.ze = 16'h0; e.up = 16'h0;
    e.cond = cond; e.pass = pass; e.st = st; e.valid = 1'b1;
    e.ill = 1'b0; e.cnt = 8'h0;
    exp_q.push_back(e);
    pushed++;
  endtask

  // Reference truth table for the condition codes, flags {C,L,F,Z,N}.
  function automatic logic modelCond(input logic [3:0] code, input logic [4:0] psr);
    logic c, l, f, z, n;
    {c, l, f, z, n} = psr;
    case (code)
      4'd0:  return z == 1'b1;
      4'd1:  return z == 1'b0;
      4'd2:  return c == 1'b1;
      4'd3:  return c == 1'b0;
      4'd4:  return l == 1'b1;
      4'd5:  return l == 1'b0;
      4'd6:  return n == 1'b1;
      4'd7:  return n == 1'b0;
      4'd8:  return f == 1'b1;
      4'd9:  return f == 1'b0;
      4'd10: return (l == 1'b0) && (z == 1'b0);
      4'd11: return (l == 1'b1) || (z == 1'b1);
      4'd12: return (n == 1'b0) && (z == 1'b0);
      4'd13: return (n == 1'b1) || (z == 1'b1);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Assert reset between edges and check the outputs before any clock edge
  // can occur, then release it on a later falling edge.
  task automatic doReset();
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    pushFull(4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0001,
             1'b0, 5'b0, 1'b0, 1'b0, 8'h00);
    -> sample_now;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: compares every queued record against the current outputs.
  initial begin
    expect_t e;
    forever begin
      @(negedge clock or sample_now);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
        if (e.full) begin
          checkOutput("operation", e.tag, {12'h0, instruction_operation}, {12'h0, e.op});
          checkOutput("destination", e.tag, {12'h0, register_destination}, {12'h0, e.rd});
          checkOutput("extra", e.tag, {12'h0, instruction_operation_extra}, {12'h0, e.ex});
          checkOutput("source", e.tag, {12'h0, register_source}, {12'h0, e.rs});
          checkOutput("imm_sign", e.tag, immediate_sign_extended, e.se);
          checkOutput("imm_zero", e.tag, immediate_zero_extended, e.ze);
          checkOutput("imm_upper", e.tag, immediate_upper, e.up);
          checkOutput("valid", e.tag, {15'h0, instruction_valid}, {15'h0, e.valid});
`ifdef ILLEGAL_DETECT_EN
          checkOutput("illegal", e.tag, {15'h0, illegal_instruction}, {15'h0, e.ill});
          checkOutput("illegal_count", e.tag, {8'h0, illegal_count}, {8'h0, e.cnt});
`endif
        end
        checkOutput("cond_pass", e.tag, {15'h0, condition_pass}, {15'h0, e.pass});
        checkOutput("imm_cond", e.tag, immediate_sign_extended_cond, e.cond);
        checkOutput("status", e.tag, {11'h0, status}, {11'h0, e.st});
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Power-on reset.
    doReset();

    // Load an instruction and all-ones flags, then reset mid-run.
    applyStimulus(1'b1, 16'h5A12, 1'b1, 5'b11111);
    pushFull(4'h5, 4'hA, 4'h1, 4'h2, 16'h0012, 16'h0012, 16'h1200, 16'h0001,
             1'b0, 5'b11111, 1'b1, 1'b0, 8'h00);
    doReset();

    // Field extraction.
    applyStimulus(1'b1, 16'h5312, 1'b0, 5'b00000);
    pushFull(4'h5, 4'h3, 4'h1, 4'h2, 16'h0012, 16'h0012, 16'h1200, 16'h0012,
             1'b1, 5'b00000, 1'b1, 1'b0, 8'h00);

    // BEQ -16 with Z clear, then after a status write setting Z.
    applyStimulus(1'b1, 16'hC0F0, 1'b0, 5'b00000);
    pushFull(4'hC, 4'h0, 4'hF, 4'h0, 16'hFFF0, 16'h00F0, 16'hF000, 16'h0001,
             1'b0, 5'b00000, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 16'h0000, 1'b1, 5'b00010);
    pushFull(4'hC, 4'h0, 4'hF, 4'h0, 16'hFFF0, 16'h00F0, 16'hF000, 16'hFFF0,
             1'b1, 5'b00010, 1'b1, 1'b0, 8'h00);

    // Prepare N-only flags so HS would fail unless the PSR load lands.
    applyStimulus(1'b1, 16'h0000, 1'b1, 5'b00001);
    pushFull(4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0001,
             1'b0, 5'b00001, 1'b1, 1'b0, 8'h00);

    // Same-edge IR and PSR load, then 10 idle cycles with junk on the inputs.
    applyStimulus(1'b1, 16'hCB05, 1'b1, 5'b00010);
    pushFull(4'hC, 4'hB, 4'h0, 4'h5, 16'h0005, 16'h0005, 16'h0500, 16'h0005,
             1'b1, 5'b00010, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 16'hFFFF, 1'b0, 5'b11111);
      pushFull(4'hC, 4'hB, 4'h0, 4'h5, 16'h0005, 16'h0005, 16'h0500, 16'h0005,
               1'b1, 5'b00010, 1'b1, 1'b0, 8'h00);
    end

    // All condition codes against all flag combinations.
    for (int code = 0; code < 16; code++) begin
      for (int p = 0; p < 32; p++) begin
        logic [3:0] c4;
        logic [4:0] p5;
        logic       exp_pass;
        c4 = 4'(code);
        p5 = 5'(p);
        exp_pass = modelCond(c4, p5);
        applyStimulus(1'b1, {4'hC, c4, 8'hF0}, 1'b1, p5);
        pushCond(exp_pass, exp_pass ? 16'hFFF0 : 16'h0001, p5);
      end
    end

`ifdef ILLEGAL_DETECT_EN
    doReset();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 16'h6000, 1'b0, 5'b00000);
      pushFull(4'h6, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0001,
               1'b0, 5'b00000, 1'b1, 1'b1, 8'(k));
      if (k < 3) begin
        applyStimulus(1'b1, 16'h5312, 1'b0, 5'b00000);
        pushFull(4'h5, 4'h3, 4'h1, 4'h2, 16'h0012, 16'h0012, 16'h1200, 16'h0012,
                 1'b1, 5'b00000, 1'b1, 1'b1, 8'(k));
      end
    end
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'b1, 16'h6000, 1'b0, 5'b00000);
    end
    pushFull(4'h6, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0001,
             1'b0, 5'b00000, 1'b1, 1'b1, 8'hFF);
`endif

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clock);
    end
    #1;
    checkOutput("scoreboard_drain", -1, 16'(popped), 16'(pushed));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
